// File: rtl/irq_pkg.sv
// Shared types and default constants for the vectored interrupt controller family.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [9:0] VEC_TIMER     = 10'h012;
    localparam logic [9:0] VEC_EXCEPTION = 10'h3FB;
    localparam logic [9:0] VEC_PORT      = 10'h3FC;
    localparam logic [9:0] VEC_SYSCALL   = 10'h3FD;

    localparam int SRC_EXCEPTION = 0;
    localparam int SRC_PORT      = 1;
    localparam int SRC_TIMER     = 2;
    localparam int SRC_SYSCALL   = 3;

    // Slice i (LSB first) is the vector for source i.
    localparam logic [39:0] DEF_VEC_TABLE = {VEC_SYSCALL, VEC_TIMER, VEC_PORT, VEC_EXCEPTION};

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder with a valid flag.
module irq_prio_enc #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Walk from the top so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: edge detect, pending latch, enable mask,
// fixed-priority dispatch and an ack/done service handshake with the core.
module irq_controller
    import irq_pkg::*;
#(
    parameter int                          NUM_SRC   = 4,
    parameter int                          ADDR_W    = 10,
    parameter logic [NUM_SRC*ADDR_W-1:0]   VEC_TABLE = DEF_VEC_TABLE,
    parameter logic [NUM_SRC-1:0]          EN_RESET  = '1,
    localparam int                         IDW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               irq_req,
    output logic [ADDR_W-1:0]  vec_addr,
    output logic [IDW-1:0]     irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] enable
);

    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] evt, clr_mask, eligible;
    logic               ack_accept;
    logic               enc_valid;
    logic [IDW-1:0]     enc_idx;
    logic [ADDR_W-1:0]  vec_sel;

    irq_state_e         state_q;
    logic               irq_req_q;
    logic [ADDR_W-1:0]  vec_addr_q;
    logic [IDW-1:0]     irq_id_q;
    logic               in_service_q;

    always_comb begin
        evt        = irq_in & ~prev_q;
        ack_accept = (state_q == ST_REQ) && irq_ack;
        clr_mask   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_mask[i] = ack_accept && (irq_id_q == IDW'(i));
        end
        prev_d    = irq_in;
        // A fresh event in the ack cycle must survive the clear.
        pending_d = (pending_q & ~clr_mask) | evt;
        enable_d  = en_we ? en_wdata : enable_q;
        eligible  = pending_q & enable_q;
    end

    irq_prio_enc #(
        .N   (NUM_SRC),
        .IDW (IDW)
    ) u_prio_enc (
        .req   (eligible),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        vec_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (enc_idx == IDW'(i)) begin
                vec_sel = VEC_TABLE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= EN_RESET;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
        end
    end

    // Dispatch FSM; irq_id/vec_addr are frozen from dispatch until the next dispatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_req_q    <= 1'b0;
            vec_addr_q   <= '0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enc_valid) begin
                        irq_id_q   <= enc_idx;
                        vec_addr_q <= vec_sel;
                        irq_req_q  <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        irq_req_q    <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (irq_done) begin
                        in_service_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    irq_req_q    <= 1'b0;
                    in_service_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq_req    = irq_req_q;
    assign vec_addr   = vec_addr_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign enable     = enable_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: dispatches are checked by a monitor against an
// expected queue of {irq_id, vec_addr}; cycle-level status is checked inline.
module tb_irq_controller;

    localparam int NUM_SRC = 4;
    localparam int ADDR_W  = 10;
    localparam int IDW     = 2;
    localparam int W       = IDW + ADDR_W;

    logic               clk;
    logic               reset;
    logic [NUM_SRC-1:0] irq_in;
    logic               en_we;
    logic [NUM_SRC-1:0] en_wdata;
    logic               irq_ack;
    logic               irq_done;
    logic               irq_req;
    logic [ADDR_W-1:0]  vec_addr;
    logic [IDW-1:0]     irq_id;
    logic               in_service;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic req_seen = 1'b0;

    irq_controller #(
        .NUM_SRC (NUM_SRC),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .en_we      (en_we),
        .en_wdata   (en_wdata),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .irq_req    (irq_req),
        .vec_addr   (vec_addr),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending),
        .enable     (enable)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] m);
        irq_in = m;
        tick();
        irq_in = '0;
    endtask

    task automatic write_en(input logic [NUM_SRC-1:0] m);
        en_we    = 1'b1;
        en_wdata = m;
        tick();
        en_we    = 1'b0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("ack_req_low", 32'(irq_req), 32'd0);
        chk("ack_in_service", 32'(in_service), 32'd1);
    endtask

    task automatic do_done();
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        chk("done_in_service", 32'(in_service), 32'd0);
    endtask

    task automatic push_exp(input logic [IDW-1:0] id, input logic [ADDR_W-1:0] v);
        exp_q.push_back({id, v});
    endtask

    // Scoreboard monitor: compare every new dispatch against the queue head
    always @(negedge clk) begin
        if (irq_req && !req_seen) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_dispatch got=%h exp=none", {irq_id, vec_addr});
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({irq_id, vec_addr} !== e) begin
                    n_err++;
                    $display("FAIL dispatch got=%h exp=%h", {irq_id, vec_addr}, e);
                end
            end
        end
        req_seen = irq_req;
    end

    initial begin
        reset    = 1'b1;
        irq_in   = '0;
        en_we    = 1'b0;
        en_wdata = '0;
        irq_ack  = 1'b0;
        irq_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_irq_req", 32'(irq_req), 32'd0);
        chk("rst_vec_addr", 32'(vec_addr), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_enable", 32'(enable), 32'hF);

        // Single timer event: pending after edge k, request after k+1
        push_exp(2'd2, 10'h012);
        pulse(4'b0100);
        chk("single_pending", 32'(pending), 32'h4);
        chk("single_req_early", 32'(irq_req), 32'd0);
        tick();
        chk("single_req", 32'(irq_req), 32'd1);
        chk("single_vec", 32'(vec_addr), 32'h012);
        chk("single_id", 32'(irq_id), 32'd2);
        do_ack();
        chk("single_pending_clr", 32'(pending), 32'h0);
        chk("single_id_held", 32'(irq_id), 32'd2);
        tick();
        chk("single_still_service", 32'(in_service), 32'd1);
        do_done();
        tick();
        chk("single_idle_req", 32'(irq_req), 32'd0);

        // Stray ack in IDLE is ignored
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("stray_ack", 32'(in_service), 32'd0);

        // Priority: 0 beats 3; 3 follows one cycle after done
        push_exp(2'd0, 10'h3FB);
        push_exp(2'd3, 10'h3FD);
        pulse(4'b1001);
        tick();
        chk("prio_first_id", 32'(irq_id), 32'd0);
        chk("prio_first_vec", 32'(vec_addr), 32'h3FB);
        do_ack();
        chk("prio_pending", 32'(pending), 32'h8);
        do_done();
        tick();
        chk("prio_second_req", 32'(irq_req), 32'd1);
        chk("prio_second_id", 32'(irq_id), 32'd3);
        chk("prio_second_vec", 32'(vec_addr), 32'h3FD);
        do_ack();
        do_done();

        // No preemption while in REQ; stray done is ignored
        push_exp(2'd2, 10'h012);
        push_exp(2'd0, 10'h3FB);
        pulse(4'b0100);
        tick();
        pulse(4'b0001);
        chk("nopre_pending", 32'(pending), 32'h5);
        chk("nopre_vec", 32'(vec_addr), 32'h012);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        chk("nopre_stray_done", 32'(irq_req), 32'd1);
        chk("nopre_vec_held", 32'(vec_addr), 32'h012);
        chk("nopre_id_held", 32'(irq_id), 32'd2);
        do_ack();
        chk("nopre_pending_after", 32'(pending), 32'h1);
        do_done();
        tick();
        chk("nopre_redispatch_id", 32'(irq_id), 32'd0);
        do_ack();
        do_done();

        // Mask: disabled source latches but is not dispatched
        write_en(4'b1110);
        chk("mask_enable", 32'(enable), 32'hE);
        pulse(4'b0001);
        tick();
        tick();
        chk("mask_pending", 32'(pending), 32'h1);
        chk("mask_no_req", 32'(irq_req), 32'd0);
        push_exp(2'd0, 10'h3FB);
        write_en(4'b1111);
        chk("mask_reenable", 32'(enable), 32'hF);
        chk("mask_req_not_yet", 32'(irq_req), 32'd0);
        tick();
        chk("mask_req", 32'(irq_req), 32'd1);
        chk("mask_id", 32'(irq_id), 32'd0);
        do_ack();
        do_done();

        // Set/clear collision on source 1 re-arms it
        push_exp(2'd1, 10'h3FC);
        push_exp(2'd1, 10'h3FC);
        pulse(4'b0010);
        tick();
        chk("coll_id", 32'(irq_id), 32'd1);
        irq_in  = 4'b0010;
        irq_ack = 1'b1;
        tick();
        irq_in  = '0;
        irq_ack = 1'b0;
        chk("coll_pending", 32'(pending), 32'h2);
        chk("coll_in_service", 32'(in_service), 32'd1);
        do_done();
        tick();
        chk("coll_redispatch", 32'(irq_req), 32'd1);
        chk("coll_redispatch_vec", 32'(vec_addr), 32'h3FC);
        do_ack();
        do_done();

        // Reset in SERVICE with other sources pending
        push_exp(2'd2, 10'h012);
        pulse(4'b0100);
        tick();
        do_ack();
        pulse(4'b1001);
        write_en(4'b0111);
        chk("midrst_pending", 32'(pending), 32'h9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_irq_req", 32'(irq_req), 32'd0);
        chk("midrst_vec", 32'(vec_addr), 32'd0);
        chk("midrst_id", 32'(irq_id), 32'd0);
        chk("midrst_in_service", 32'(in_service), 32'd0);
        chk("midrst_pending_clr", 32'(pending), 32'd0);
        chk("midrst_enable", 32'(enable), 32'hF);
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_no_req", 32'(irq_req), 32'd0);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised vectored interrupt controller between the interrupt sources (exception, port, timer, syscall and any added later) and the processor's fetch/PC logic. It edge-detects each source, latches pending requests, applies a software-writable enable mask, and arbitrates by fixed priority. It presents one vector address per dispatch and tracks the service period through an ack/done handshake with the core. Fully synchronous; it replaces the asynchronous event-triggered interrupt logic.

## Interface
- NUM_SRC, 4: number of interrupt sources, 1..16; index 0 has the highest priority.
- ADDR_W, 10: vector/PC address width.
- VEC_TABLE, {10'h3FD,10'h012,10'h3FC,10'h3FB}: flattened NUM_SRC*ADDR_W vector table; slice i is the vector for source i. The default maps 0=exception, 1=port, 2=timer, 3=syscall.
- EN_RESET, all ones: enable mask value loaded at reset.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- irq_in  in  NUM_SRC  source request lines, already synchronous to clk; rising edge = event.
- en_we  in  1  writes en_wdata into the enable mask.
- en_wdata  in  NUM_SRC  new enable mask.
- irq_ack  in  1  core has taken the vector; valid only while irq_req=1.
- irq_done  in  1  core has finished the handler (return-from-interrupt).
- irq_req  out  1  interrupt request to the core.
- vec_addr  out  ADDR_W  handler address; valid while irq_req=1.
- irq_id  out  $clog2(NUM_SRC) (min 1)  index of the source being requested or serviced.
- in_service  out  1  a handler is running.
- pending  out  NUM_SRC  latched pending bits, for debug and status.
- enable  out  NUM_SRC  current enable mask.

## Operation
- Edge detect: prev <= irq_in every cycle. An event on source i is irq_in[i] & ~prev[i].
- Pending: pending[i] is set by an event and cleared by an accepted ack for source i. If set and clear occur in the same cycle, set wins.
- Disabled sources still latch pending bits but are never dispatched. A pending bit is dispatched once its source is re-enabled.
- The mask write takes effect on the next cycle and affects arbitration only.
- FSM states:
  - IDLE: if pending & enable is nonzero, load irq_id and vec_addr from the lowest set index, set irq_req=1, and go to REQ.
  - REQ: irq_req, irq_id and vec_addr stay frozen until irq_ack. Higher-priority arrivals and mask changes do not preempt. On irq_ack, clear pending[irq_id], drop irq_req, set in_service=1, and go to SERVICE.
  - SERVICE: irq_id is held. On irq_done, clear in_service and go to IDLE. There is no nesting.
- irq_ack outside REQ and irq_done outside SERVICE are ignored.
- A new event on the source being serviced re-sets its pending bit. That source is dispatched again after irq_done.
- Reset, including mid-operation, returns the block to IDLE and discards any in-flight request.

## Timing
- Reset values: irq_req=0, vec_addr=0, irq_id=0, in_service=0, pending=0, prev=0, enable=EN_RESET, state IDLE.
- Latency from IDLE: the event is sampled at edge k, so pending is high after k. irq_req and vec_addr are registered high after edge k+1. Total latency is 2 cycles.
- Ack is sampled at edge a. irq_req is low and in_service is high after a.
- Done is sampled at edge d, so the state is IDLE after d. The next irq_req is high after d+1 at the earliest.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package irq_pkg holds:
  - the state enum (IDLE, REQ, SERVICE);
  - the default vector constants VEC_TIMER=10'h012, VEC_EXCEPTION=10'h3FB, VEC_PORT=10'h3FC, VEC_SYSCALL=10'h3FD;
  - the default source index constants.
- Sub-module irq_prio_enc is a purely combinational, parametrised lowest-index-first encoder producing a valid flag and an index. It is reused by later multi-level controllers.

## Test plan
- Single event: reset, then raise irq_in[2] (timer) for 1 cycle. irq_req goes high 2 cycles later with vec_addr=0x012 and irq_id=2. Ack clears pending[2] and sets in_service; done returns to IDLE.
- Priority: raise irq_in[3] and irq_in[0] in the same cycle. The first dispatch is id 0 at 0x3FB. After done, id 3 at 0x3FD is dispatched 2 cycles later.
- No preemption: while in REQ for id 2, raise irq_in[0]. vec_addr stays 0x012 until ack. After done, id 0 is dispatched.
- Mask: write enable=4'b1110, then raise irq_in[0]. pending[0]=1 and irq_req stays 0. Write enable=4'b1111; irq_req rises next cycle with id 0.
- Set/clear collision and re-arm: an event on source 1 in the same cycle as its ack leaves pending[1]=1. After done, source 1 is redispatched.
- Reset mid-SERVICE: assert reset during SERVICE with other bits pending. All outputs and pending return to reset values and no request follows.
